// File: rtl/reg_file_ctrl_if.sv
// Bundle between the command controller, the UART RX byte port, the register file port and the TX FIFO write port.
// master = controller side; slave = surrounding logic (RX, register file, TX FIFO).
interface reg_file_ctrl_if #(
   parameter int unsigned Width  = 8,
   parameter int unsigned ADDR_W = 4
);
   logic [Width-1:0]  RX_P_DATA;
   logic              RX_D_VLD;
   logic [Width-1:0]  RdData;
   logic              RdData_VLD;
   logic              FIFO_FULL;
   logic [ADDR_W-1:0] Address;
   logic [Width-1:0]  WrData;
   logic              WrEn;
   logic              RdEn;
   logic [Width-1:0]  TX_P_DATA;
   logic              TX_D_VLD;
   logic              Busy;

   modport master (
      input  RX_P_DATA, RX_D_VLD, RdData, RdData_VLD, FIFO_FULL,
      output Address, WrData, WrEn, RdEn, TX_P_DATA, TX_D_VLD, Busy
   );

   modport slave (
      output RX_P_DATA, RX_D_VLD, RdData, RdData_VLD, FIFO_FULL,
      input  Address, WrData, WrEn, RdEn, TX_P_DATA, TX_D_VLD, Busy
   );
endinterface

// File: rtl/reg_file_ctrl.sv
// Parses AA/BB byte frames into register-file write/read strobes and forwards read data (or ERR_BYTE on timeout)
// to the TX FIFO, holding a byte while FIFO_FULL. Macro RF_CTRL_WR_ACK_EN: each completed write also sends ACK_BYTE.
module reg_file_ctrl #(
   parameter int unsigned      Width      = 8,
   parameter int unsigned      Depth      = 16,
   parameter logic [Width-1:0] WR_CMD     = 8'hAA,
   parameter logic [Width-1:0] RD_CMD     = 8'hBB,
   parameter int unsigned      RD_TIMEOUT = 4,
   parameter logic [Width-1:0] ERR_BYTE   = 8'hEE
`ifdef RF_CTRL_WR_ACK_EN
   ,parameter logic [Width-1:0] ACK_BYTE  = 8'hA5
`endif
) (
   input logic             CLK,
   input logic             RST,
   reg_file_ctrl_if.master bus
);
   localparam int unsigned ADDR_W = $clog2(Depth);
   localparam int unsigned CNT_W  = $clog2(RD_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND
   } state_t;

   state_t             state_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [Width-1:0]   wr_data_q;
   logic               wr_en_q;
   logic               rd_en_q;
   logic [Width-1:0]   tx_data_q;
   logic               tx_vld_q;
   logic               busy_q;
   logic [CNT_W-1:0]   tmo_cnt_q;
   logic [CNT_W-1:0]   tmo_cnt_d;

   assign tmo_cnt_d = tmo_cnt_q + 1'b1;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         tx_data_q <= '0;
         tx_vld_q  <= 1'b0;
         busy_q    <= 1'b0;
         tmo_cnt_q <= '0;
      end else begin
         wr_en_q <= 1'b0;
         rd_en_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.RX_D_VLD && bus.RX_P_DATA == WR_CMD) begin
                  state_q <= WR_ADDR;
                  busy_q  <= 1'b1;
               end else if (bus.RX_D_VLD && bus.RX_P_DATA == RD_CMD) begin
                  state_q <= RD_ADDR;
                  busy_q  <= 1'b1;
               end
            end
            WR_ADDR: begin
               if (bus.RX_D_VLD) begin
                  addr_q  <= bus.RX_P_DATA[ADDR_W-1:0];
                  state_q <= WR_DATA;
               end
            end
            WR_DATA: begin
               if (bus.RX_D_VLD) begin
                  wr_data_q <= bus.RX_P_DATA;
                  wr_en_q   <= 1'b1;
                  state_q   <= WR_EXEC;
               end
            end
            WR_EXEC: begin
`ifdef RF_CTRL_WR_ACK_EN
               tx_data_q <= ACK_BYTE;
               tx_vld_q  <= !bus.FIFO_FULL;
               state_q   <= TX_SEND;
`else
               state_q   <= IDLE;
               busy_q    <= 1'b0;
`endif
            end
            RD_ADDR: begin
               if (bus.RX_D_VLD) begin
                  addr_q  <= bus.RX_P_DATA[ADDR_W-1:0];
                  rd_en_q <= 1'b1;
                  state_q <= RD_EXEC;
               end
            end
            RD_EXEC: begin
               tmo_cnt_q <= '0;
               state_q   <= RD_WAIT;
            end
            RD_WAIT: begin
               // The strobe is raised on the same edge the byte is loaded, so TX_D_VLD lands one cycle after RdData_VLD.
               if (bus.RdData_VLD) begin
                  tx_data_q <= bus.RdData;
                  tx_vld_q  <= !bus.FIFO_FULL;
                  state_q   <= TX_SEND;
               end else if (tmo_cnt_d == CNT_W'(RD_TIMEOUT)) begin
                  tx_data_q <= ERR_BYTE;
                  tx_vld_q  <= !bus.FIFO_FULL;
                  state_q   <= TX_SEND;
               end else begin
                  tmo_cnt_q <= tmo_cnt_d;
               end
            end
            TX_SEND: begin
               if (tx_vld_q) begin
                  tx_vld_q <= 1'b0;
                  state_q  <= IDLE;
                  busy_q   <= 1'b0;
               end else begin
                  tx_vld_q <= !bus.FIFO_FULL;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Address   = addr_q;
   assign bus.WrData    = wr_data_q;
   assign bus.WrEn      = wr_en_q;
   assign bus.RdEn      = rd_en_q;
   assign bus.TX_P_DATA = tx_data_q;
   assign bus.TX_D_VLD  = tx_vld_q;
   assign bus.Busy      = busy_q;
endmodule
